reduction_result_collector: RTL

Sits directly downstream of the Long_Range reduction tree, which is fully pipelined and has no stall input. The block tracks which operand sets were fed into the tree and realigns a valid/tag pipeline with the tree's fixed latency. It captures each scalar sum into a small output FIFO and presents it on a ready/valid port. Credit-based flow control toward the upstream grid feeder guarantees that no result leaving the tree is ever lost; frame counters mark the last result and signal frame completion.

---
 rtl/reduction_result_collector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reduction_result_collector.sv
// Realigns valid/tag with the fixed-latency reduction tree, buffers each sum in a
// show-ahead FIFO and throttles upstream issue with credits so no result is lost.
module reduction_result_collector #(
  parameter int TREE_LATENCY = 21,
  parameter int FIFO_DEPTH   = 8,
  parameter int TAG_W        = 6,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] frame_len_i,
  input  logic             in_valid_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             in_ready_o,
  input  logic [31:0]      tree_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             overflow_err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] frame_len_q, issued_q, popped_q;
  logic [OCC_W-1:0] outstanding_q, fifo_count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             overflow_q;

  logic [TREE_LATENCY-1:0] pipe_valid_q;
  logic [TAG_W-1:0]        pipe_tag_q [TREE_LATENCY];

  logic [31:0]      mem_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag_q  [FIFO_DEPTH];

  logic             accept, pop, push_req, push, fifo_full;
  logic [CNT_W-1:0] issued_d, popped_d;

  assign in_ready_o = (state_q == RUN) && (outstanding_q < OCC_W'(FIFO_DEPTH))
                      && (issued_q < frame_len_q);
  assign accept     = in_valid_i && in_ready_o;
  assign out_valid_o = (fifo_count_q != '0);
  assign pop        = out_valid_o && out_ready_i;
  assign fifo_full  = (fifo_count_q == OCC_W'(FIFO_DEPTH));
  assign push_req   = pipe_valid_q[TREE_LATENCY-1];
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  assign issued_d = issued_q + CNT_W'(1);
  assign popped_d = popped_q + CNT_W'(1);

  assign out_data_o     = out_valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign out_tag_o      = out_valid_o ? mem_tag_q[rd_ptr_q]  : '0;
  assign out_last_o     = out_valid_o && (popped_q == frame_len_q - CNT_W'(1));
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = (state_q == DONE);
  assign overflow_err_o = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      frame_len_q <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
    end else begin
      if (pop) popped_q <= popped_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (frame_len_i != '0) begin
              frame_len_q <= frame_len_i;
              issued_q    <= '0;
              popped_q    <= '0;
              state_q     <= RUN;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            issued_q <= issued_d;
            if (issued_d == frame_len_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (popped_d == frame_len_q)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Credits: results in the tree plus results waiting in the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (accept && !pop) begin
      outstanding_q <= outstanding_q + OCC_W'(1);
    end else if (pop && !accept) begin
      outstanding_q <= outstanding_q - OCC_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < TREE_LATENCY; gi++) begin : g_align
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pipe_valid_q[gi] <= 1'b0;
          pipe_tag_q[gi]   <= '0;
        end else if (gi == 0) begin
          pipe_valid_q[gi] <= accept;
          pipe_tag_q[gi]   <= in_tag_i;
        end else begin
          pipe_valid_q[gi] <= pipe_valid_q[(gi == 0) ? 0 : gi - 1];
          pipe_tag_q[gi]   <= pipe_tag_q[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= tree_result_i;
      mem_tag_q[wr_ptr_q]  <= pipe_tag_q[TREE_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fifo_count_q <= fifo_count_q + OCC_W'(1);
      else if (pop && !push) fifo_count_q <= fifo_count_q - OCC_W'(1);
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

endmodule
